// File: rtl/mfp_dual_port_ram_arbiter.sv
// Two-requester arbiter in front of a single-clock dual-port RAM: independent
// round-robin on the read and write ports plus a full-RAM clear sequencer.
module mfp_dual_port_ram_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start,
    output logic                  clear_busy,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] last_read_addr;
    logic                  rd_last_b;
    logic                  wr_last_b;
    logic                  open;
    logic                  a_rd_cand, b_rd_cand, a_wr_cand, b_wr_cand;
    logic                  a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;

    // Requesters are locked out during reset and while the sequencer owns the RAM.
    assign open = rst_n && (state == IDLE);

    always_comb begin
        a_rd_cand = a_req && !a_we;
        b_rd_cand = b_req && !b_we;
        a_wr_cand = a_req && a_we;
        b_wr_cand = b_req && b_we;
        a_rd_gnt  = open && a_rd_cand && (!b_rd_cand || rd_last_b);
        b_rd_gnt  = open && b_rd_cand && (!a_rd_cand || !rd_last_b);
        a_wr_gnt  = open && a_wr_cand && (!b_wr_cand || wr_last_b);
        b_wr_gnt  = open && b_wr_cand && (!a_wr_cand || !wr_last_b);
    end

    assign a_gnt            = a_rd_gnt || a_wr_gnt;
    assign b_gnt            = b_rd_gnt || b_wr_gnt;
    assign clear_busy       = (state == CLEAR);
    assign rdata            = ram_read_data;
    assign ram_write_enable = rst_n && (clear_busy || a_wr_gnt || b_wr_gnt);
    assign ram_write_addr   = clear_busy ? cnt : (a_wr_gnt ? a_addr : b_addr);
    assign ram_write_data   = clear_busy ? CLEAR_VALUE : (a_wr_gnt ? a_wdata : b_wdata);
    assign ram_read_addr    = a_rd_gnt ? a_addr : (b_rd_gnt ? b_addr : last_read_addr);

    always_ff @(posedge clk) begin
        if (a_rd_gnt || b_rd_gnt) begin
            last_read_addr <= ram_read_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_last_b <= 1'b1;
            wr_last_b <= 1'b1;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
        end else begin
            a_rvalid <= a_rd_gnt;
            b_rvalid <= b_rd_gnt;
            if (a_rd_gnt || b_rd_gnt) begin
                rd_last_b <= b_rd_gnt;
            end
            if (a_wr_gnt || b_wr_gnt) begin
                wr_last_b <= b_wr_gnt;
            end
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    // Last address written: counter wraps back to zero on the way out.
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_dual_port_ram_arbiter.sv
// Directed bench for mfp_dual_port_ram_arbiter with a behavioural read-before-write RAM.
module tb_mfp_dual_port_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_start = 1'b0;
    logic        clear_busy;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [5:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0] rdata;
    logic [5:0]  ram_read_addr, ram_write_addr;
    logic [31:0] ram_write_data;
    logic        ram_write_enable;
    logic [31:0] ram_read_data = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mfp_dual_port_ram_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .CLEAR_VALUE(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_busy(clear_busy),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data), .ram_write_enable(ram_write_enable),
        .ram_read_data(ram_read_data)
    );

    // RAM model: registered read, read-before-write, preloaded with A000_0000 + address.
    logic [31:0] mem [64];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem_init <= 1'b1;
        end else if (ram_write_enable) begin
            mem[ram_write_addr] <= ram_write_data;
        end
        ram_read_data <= mem[ram_read_addr];
    end

    typedef struct {
        logic        a_req, a_we;
        logic [5:0]  a_addr;
        logic [31:0] a_wdata;
        logic        b_req, b_we;
        logic [5:0]  b_addr;
        logic [31:0] b_wdata;
        logic        e_a_gnt, e_b_gnt, e_we;
        logic [5:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_a_rv, e_b_rv;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(int ar, int aw, int aa, logic [31:0] ad,
                                int br, int bw, int ba, logic [31:0] bd,
                                int eag, int ebg, int ewe, int ewa, logic [31:0] ewd,
                                int earv, int ebrv, logic [31:0] erd);
        vec_t v;
        v.a_req = ar[0];   v.a_we = aw[0];   v.a_addr = aa[5:0];   v.a_wdata = ad;
        v.b_req = br[0];   v.b_we = bw[0];   v.b_addr = ba[5:0];   v.b_wdata = bd;
        v.e_a_gnt = eag[0]; v.e_b_gnt = ebg[0]; v.e_we = ewe[0];
        v.e_waddr = ewa[5:0]; v.e_wdata = ewd;
        v.e_a_rv = earv[0]; v.e_b_rv = ebrv[0]; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int is_a, input int addr, input logic [31:0] exp, input string name);
        a_req = (is_a != 0); a_we = 1'b0; a_addr = addr[5:0];
        b_req = (is_a == 0); b_we = 1'b0; b_addr = addr[5:0];
        #1;
        chk1({name, "_gnt"}, (is_a != 0) ? a_gnt : b_gnt, 1'b1);
        step();
        chk1({name, "_rvalid"}, (is_a != 0) ? a_rvalid : b_rvalid, 1'b1);
        chk32({name, "_rdata"}, rdata, exp);
        a_req = 1'b0; b_req = 1'b0;
    endtask

    // Runs from the first busy cycle until clear_busy drops (bounded), optionally
    // pulling reset in the middle of busy cycle number reset_at.
    task automatic count_busy(input int reset_at, output int busy, output int viol);
        busy = 0;
        viol = 0;
        for (int k = 0; k < 100; k++) begin
            if (!clear_busy) break;
            clear_start = (k == 5);
            a_req = 1'b1; a_we = 1'b0; a_addr = 6'h00;
            b_req = 1'b1; b_we = 1'b0; b_addr = 6'h3F;
            #1;
            if (a_gnt || b_gnt || !ram_write_enable || ram_write_addr != busy[5:0] ||
                ram_write_data != 32'h0) viol++;
            busy++;
            if (busy == reset_at) begin
                rst_n = 1'b0;
                #1;
                break;
            end
            step();
        end
        clear_start = 1'b0;
    endtask

    vec_t vecs[14];
    int   busy, viol;

    initial begin
        vecs[0]  = mk(1,1,'h05,32'hDEADBEEF, 0,0,0,0,           1,0,1,'h05,32'hDEADBEEF, 0,0,0);
        vecs[1]  = mk(1,0,'h05,0,            0,0,0,0,           1,0,0,0,0,               1,0,32'hDEADBEEF);
        vecs[2]  = mk(0,0,0,0,               1,0,'h11,0,        0,1,0,0,0,               0,1,32'hA0000011);
        vecs[3]  = mk(1,0,'h05,0,            1,0,'h11,0,        1,0,0,0,0,               1,0,32'hDEADBEEF);
        vecs[4]  = mk(1,0,'h05,0,            1,0,'h11,0,        0,1,0,0,0,               0,1,32'hA0000011);
        vecs[5]  = mk(1,0,'h05,0,            1,0,'h11,0,        1,0,0,0,0,               1,0,32'hDEADBEEF);
        vecs[6]  = mk(1,0,'h05,0,            1,0,'h11,0,        0,1,0,0,0,               0,1,32'hA0000011);
        vecs[7]  = mk(1,1,'h11,32'h12345678, 1,0,'h11,0,        1,1,1,'h11,32'h12345678, 0,1,32'hA0000011);
        vecs[8]  = mk(0,0,0,0,               1,0,'h11,0,        0,1,0,0,0,               0,1,32'h12345678);
        vecs[9]  = mk(1,1,'h20,32'h1,        1,1,'h21,32'h2,    0,1,1,'h21,32'h2,        0,0,0);
        vecs[10] = mk(1,1,'h20,32'h1,        0,0,0,0,           1,0,1,'h20,32'h1,        0,0,0);
        vecs[11] = mk(1,0,'h20,0,            1,0,'h21,0,        1,0,0,0,0,               1,0,32'h1);
        vecs[12] = mk(0,0,0,0,               1,0,'h21,0,        0,1,0,0,0,               0,1,32'h2);
        vecs[13] = mk(0,0,0,0,               0,0,0,0,           0,0,0,0,0,               0,0,0);

        // Reset holds everything quiet even with both requesters asking.
        a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b0;
        step(); step(); step();
        chk1("rst_a_gnt", a_gnt, 1'b0);
        chk1("rst_b_gnt", b_gnt, 1'b0);
        chk1("rst_we", ram_write_enable, 1'b0);
        chk1("rst_a_rvalid", a_rvalid, 1'b0);
        chk1("rst_b_rvalid", b_rvalid, 1'b0);
        chk1("rst_busy", clear_busy, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
            #1;
            chk1($sformatf("v%0d_a_gnt", i), a_gnt, vecs[i].e_a_gnt);
            chk1($sformatf("v%0d_b_gnt", i), b_gnt, vecs[i].e_b_gnt);
            chk1($sformatf("v%0d_we", i), ram_write_enable, vecs[i].e_we);
            if (vecs[i].e_we) begin
                chk32($sformatf("v%0d_waddr", i), 32'(ram_write_addr), 32'(vecs[i].e_waddr));
                chk32($sformatf("v%0d_wdata", i), ram_write_data, vecs[i].e_wdata);
            end
            step();
            chk1($sformatf("v%0d_a_rvalid", i), a_rvalid, vecs[i].e_a_rv);
            chk1($sformatf("v%0d_b_rvalid", i), b_rvalid, vecs[i].e_b_rv);
            if (vecs[i].e_a_rv || vecs[i].e_b_rv)
                chk32($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
        end

        // Clear with a read granted in the same cycle as clear_start.
        clear_start = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05; b_req = 1'b0;
        #1;
        chk1("pre_clear_a_gnt", a_gnt, 1'b1);
        step();
        chk1("clear_busy_rise", clear_busy, 1'b1);
        chk1("pre_clear_rvalid", a_rvalid, 1'b1);
        chk32("pre_clear_rdata", rdata, 32'hDEADBEEF);
        count_busy(0, busy, viol);
        chk32("clear_cycles", 32'(busy), 32'd64);
        chk32("clear_violations", 32'(viol), 32'd0);
        chk1("clear_busy_fall", clear_busy, 1'b0);
        chk1("resume_b_gnt", b_gnt, 1'b1);
        chk1("resume_a_gnt", a_gnt, 1'b0);
        step();
        chk1("resume_b_rvalid", b_rvalid, 1'b1);
        chk32("clear_rd_3f", rdata, 32'h0);
        a_req = 1'b0; b_req = 1'b0;
        do_read(1, 'h00, 32'h0, "clear_rd_00");
        do_read(1, 'h05, 32'h0, "clear_rd_05");

        // Reset in the middle of a clear, then a full clear again.
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        count_busy(10, busy, viol);
        chk1("midrst_busy", clear_busy, 1'b0);
        chk1("midrst_a_gnt", a_gnt, 1'b0);
        chk1("midrst_we", ram_write_enable, 1'b0);
        chk32("midrst_violations", 32'(viol), 32'd0);
        step();
        rst_n = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        count_busy(0, busy, viol);
        chk32("reclear_cycles", 32'(busy), 32'd64);
        chk32("reclear_violations", 32'(viol), 32'd0);
        chk1("rr_reset_a_gnt", a_gnt, 1'b1);
        chk1("rr_reset_b_gnt", b_gnt, 1'b0);
        step();
        a_req = 1'b0; b_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mfp_dual_port_ram_arbiter.md
# mfp_dual_port_ram_arbiter

Shares one single-clock dual-port RAM (one registered read port, one write port, ADDR_WIDTH x DATA_WIDTH) between two requesters, A and B, such as the CPU-side bus and a DMA/video engine. Read and write ports are arbitrated independently, each with a two-way round-robin. A built-in clear sequencer fills the whole RAM with a constant after a start pulse. The block sits directly in front of the RAM instance and drives all of its ports.

## Interface
- ADDR_WIDTH, 6, RAM address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 32, RAM data width.
- CLEAR_VALUE, 0, word written to every location by the clear sequencer.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_start  in  1  one-cycle pulse that starts a full-RAM clear.
- clear_busy  out  1  high while the clear sequencer owns the write port.
- a_req / b_req  in  1  request valid.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  ADDR_WIDTH  request address.
- a_wdata / b_wdata  in  DATA_WIDTH  write data.
- a_gnt / b_gnt  out  1  combinational; the request is accepted at the next rising edge.
- a_rvalid / b_rvalid  out  1  registered; read data valid for that requester.
- rdata  out  DATA_WIDTH  pass-through of ram_read_data, shared by both requesters.
- ram_read_addr  out  ADDR_WIDTH  to RAM read_addr.
- ram_write_addr  out  ADDR_WIDTH  to RAM write_addr.
- ram_write_data  out  DATA_WIDTH  to RAM write_data.
- ram_write_enable  out  1  to RAM write_enable.
- ram_read_data  in  DATA_WIDTH  from RAM read_data (registered in the RAM, 1-cycle latency).

## Operation
- Requester protocol:
  - req, we, addr and wdata must be held stable until gnt is high.
  - A transfer completes on the edge where req and gnt are both high.
  - A new request may be presented in the next cycle.
- Read port:
  - Candidates are the requesters with req=1 and we=0.
  - A single candidate is granted.
  - With two candidates, the requester not granted most recently on the read port wins.
  - ram_read_addr = addr of the granted requester, otherwise the last value (don't-care).
- Write port:
  - Same rule among requesters with req=1 and we=1, using its own round-robin pointer.
  - ram_write_enable = 1 only for a granted write.
  - ram_write_addr and ram_write_data are muxed from the winner.
- A read from one requester and a write from the other are both granted in the same cycle.
- Round-robin pointer update:
  - Each port's "last granted" flag updates only on a grant for that port.
  - Reset value of both pointers = B, so A wins the first contention.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_start=1; the counter loads 0.
  - In CLEAR, each cycle writes CLEAR_VALUE at the counter address, then increments the counter.
  - CLEAR -> IDLE after writing address 2^ADDR_WIDTH-1; the counter wraps to 0.
  - clear_start is ignored while in CLEAR.
  - In CLEAR, a_gnt and b_gnt are 0 for all requests, reads included.
  - A read granted in the cycle before CLEAR is entered still returns its rvalid.
- Reset values:
  - State IDLE, counter 0, both pointers = B.
  - a_rvalid = b_rvalid = 0, clear_busy = 0.
  - While rst_n=0, gnts and ram_write_enable are forced to 0.
- Reset mid-clear returns to IDLE. The RAM contents are then unspecified (partially cleared); reset never touches RAM contents.

## Timing
- Write: data is in the RAM after the accepting edge N. A read of that address accepted at edge N+1 or later returns the new data.
- Read accepted at edge N:
  - requester's rvalid is high for exactly the cycle after edge N;
  - rdata is valid in that same cycle.
- Back-to-back reads by one requester give one rvalid per cycle.
- Read and write to the same address accepted on the same edge: the read returns the old data (RAM is read-before-write).
- clear_start sampled at edge N:
  - clear_busy is high from after edge N until after edge N+2^ADDR_WIDTH;
  - the clear occupies exactly 2^ADDR_WIDTH write cycles.
- Requester grants resume in the cycle after clear_busy falls.

## Test plan
- Reset: with rst_n=0 and a_req=b_req=1, both gnts=0, rvalids=0, ram_write_enable=0. After release, A write to 0x05 with 0xDEADBEEF is granted in the first cycle.
- Single read: A reads 0x05 -> a_rvalid high one cycle later with rdata=0xDEADBEEF; b_rvalid stays 0.
- Read contention: A and B both hold read requests for 4 cycles -> grants alternate A, B, A, B; each rvalid follows its grant by one cycle.
- Parallel ports: A writes 0x11 := 0x12345678 while B reads 0x11 in the same cycle -> both granted, B receives the old value. A following B read returns 0x12345678.
- Clear: clear_start with ADDR_WIDTH=6 -> clear_busy high for exactly 64 cycles with no gnts. Reads of 0x00, 0x05 and 0x3F then return CLEAR_VALUE.
- Reset mid-clear: assert rst_n=0 at cycle 10 of the clear -> clear_busy drops immediately. After release, a new clear_start runs the full 64 cycles.
